// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module  : aes_inv_key_schedule
// Brief   : AES-128 round-key generator for decryption. It expands the cipher
//           key forward to round 10, then streams keys 10..0 over valid/ready.
//           Optional macro INV_KEY_CACHE_EN reuses round key 10 for a repeated key.
// Revision: 1.0 - initial release
// ============================================================================
module aes_inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         keyValid_i,
    input  logic [127:0] key_i,
    output logic         keyReady_o,
    output logic         roundKeyValid_o,
    input  logic         roundKeyReady_i,
    output logic [127:0] roundKey_o,
    output logic [3:0]   roundIndex_o,
    output logic         lastKey_o
);

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_inv_key_schedule supports only NR == 10");
        end
    endgenerate

    localparam logic [3:0] C_LAST_CNT = 4'(NR);
    localparam logic [3:0] C_PRE_LAST = 4'(NR - 1);

    localparam logic [0:255][7:0] C_SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {C_SBOX[w[31:24]], C_SBOX[w[23:16]], C_SBOX[w[15:8]], C_SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    state_t       state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   cnt_q, cnt_d;

    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_fwd_t, w_fwd0, w_fwd1, w_fwd2, w_fwd3;
    logic [31:0]  w_inv0, w_inv1, w_inv2, w_inv3;
    logic [127:0] w_fwd_rk, w_inv_rk;

    assign w_w0 = rk_q[127:96];
    assign w_w1 = rk_q[95:64];
    assign w_w2 = rk_q[63:32];
    assign w_w3 = rk_q[31:0];

    // Forward step: produces round key cnt+1 from round key cnt.
    assign w_fwd_t  = sub_word(rot_word(w_w3)) ^ {rcon(cnt_q + 4'd1), 24'h0};
    assign w_fwd0   = w_w0 ^ w_fwd_t;
    assign w_fwd1   = w_w1 ^ w_fwd0;
    assign w_fwd2   = w_w2 ^ w_fwd1;
    assign w_fwd3   = w_w3 ^ w_fwd2;
    assign w_fwd_rk = {w_fwd0, w_fwd1, w_fwd2, w_fwd3};

    // Inverse step: w3 of the previous key must be recovered before w0 can be.
    assign w_inv3   = w_w3 ^ w_w2;
    assign w_inv2   = w_w2 ^ w_w1;
    assign w_inv1   = w_w1 ^ w_w0;
    assign w_inv0   = w_w0 ^ sub_word(rot_word(w_inv3)) ^ {rcon(cnt_q), 24'h0};
    assign w_inv_rk = {w_inv0, w_inv1, w_inv2, w_inv3};

`ifdef INV_KEY_CACHE_EN
    logic [127:0] lastKey_q, lastKey_d;
    logic [127:0] rk10_q, rk10_d;
    logic         cacheHit_q, cacheHit_d;
    logic         w_hit;

    assign w_hit = cacheHit_q && (key_i == lastKey_q);
`endif

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        cnt_d   = cnt_q;
`ifdef INV_KEY_CACHE_EN
        lastKey_d  = lastKey_q;
        rk10_d     = rk10_q;
        cacheHit_d = cacheHit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (keyValid_i) begin
`ifdef INV_KEY_CACHE_EN
                    if (w_hit) begin
                        rk_d    = rk10_q;
                        cnt_d   = C_LAST_CNT;
                        state_d = ST_EMIT;
                    end else begin
                        rk_d       = key_i;
                        cnt_d      = 4'd0;
                        state_d    = ST_EXPAND;
                        lastKey_d  = key_i;
                        cacheHit_d = 1'b0;
                    end
`else
                    rk_d    = key_i;
                    cnt_d   = 4'd0;
                    state_d = ST_EXPAND;
`endif
                end
            end
            ST_EXPAND: begin
                rk_d  = w_fwd_rk;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == C_PRE_LAST) begin
                    state_d = ST_EMIT;
`ifdef INV_KEY_CACHE_EN
                    rk10_d     = w_fwd_rk;
                    cacheHit_d = 1'b1;
`endif
                end
            end
            ST_EMIT: begin
                if (roundKeyReady_i) begin
                    if (cnt_q != 4'd0) begin
                        rk_d  = w_inv_rk;
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            cnt_q   <= '0;
`ifdef INV_KEY_CACHE_EN
            lastKey_q  <= '0;
            rk10_q     <= '0;
            cacheHit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            cnt_q   <= cnt_d;
`ifdef INV_KEY_CACHE_EN
            lastKey_q  <= lastKey_d;
            rk10_q     <= rk10_d;
            cacheHit_q <= cacheHit_d;
`endif
        end
    end

    // Key and index read as zero outside EMIT so idle outputs match reset values.
    assign keyReady_o      = (state_q == ST_IDLE);
    assign roundKeyValid_o = (state_q == ST_EMIT);
    assign roundKey_o      = (state_q == ST_EMIT) ? rk_q : '0;
    assign roundIndex_o    = (state_q == ST_EMIT) ? cnt_q : 4'd0;
    assign lastKey_o       = (state_q == ST_EMIT) && (cnt_q == 4'd0);

    always_comb begin
        if (!reset_i && keyValid_i) begin
            a_key_known: assert (!$isunknown(key_i));
        end
        if (!reset_i && roundKeyValid_o) begin
            a_ready_known: assert (!$isunknown(roundKeyReady_i));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_inv_key_schedule
// Brief   : Randomised self-checking bench for aes_inv_key_schedule against a
//           FIPS-197 key-expansion model built from GF(2^8) arithmetic.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_inv_key_schedule;

    logic         clock = 1'b0;
    logic         reset;
    logic         keyValid;
    logic [127:0] key;
    logic         keyReady;
    logic         roundKeyValid;
    logic         roundKeyReady;
    logic [127:0] roundKey;
    logic [3:0]   roundIndex;
    logic         lastKey;

    aes_inv_key_schedule #(.NR(10)) dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .keyValid_i      (keyValid),
        .key_i           (key),
        .keyReady_o      (keyReady),
        .roundKeyValid_o (roundKeyValid),
        .roundKeyReady_i (roundKeyReady),
        .roundKey_o      (roundKey),
        .roundIndex_o    (roundIndex),
        .lastKey_o       (lastKey)
    );

    always #5 clock = ~clock;

`ifdef INV_KEY_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] SEQ_KEY  = 128'h00010203_04050607_08090a0b_0c0d0e0f;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] ref_rk [11];

    // Expected-cache model: which key (if any) the DUT may legally reuse.
    bit           cache_valid = 1'b0;
    logic [127:0] cache_key   = '0;

    // Observations of the most recent run_schedule call.
    logic [127:0] obs_key  [11];
    logic [3:0]   obs_idx  [11];
    logic         obs_last [11];
    int           obs_lat, exp_lat, obs_cycles, stall_viol, kr_viol;
    bit           timed_out, start_ready, end_kr, end_rkv;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b};
        return d[15-n -: 8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] xb, inv;
            xb  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                logic [7:0] yb;
                yb = y[7:0];
                if (gmul(xb, yb) == 8'h01) inv = yb;
            end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic ref_schedule(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  r;
        r = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t[31:24] = t[31:24] ^ r;
                r = xtime(r);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) ref_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offers key k, collects all 11 round keys with ready asserted ready_pct% of
    // cycles; optionally keeps keyValid high with k2 for the whole run.
    task automatic run_schedule(input logic [127:0] k, input int ready_pct,
                                input bit hold_other, input logic [127:0] k2);
        int         n;
        bit         stalled, hit;
        logic [127:0] prev_key;
        logic [3:0]   prev_idx;
        stall_viol = 0;
        kr_viol    = 0;
        timed_out  = 1'b0;
        obs_cycles = 0;
        for (int i = 0; i < 11; i++) begin
            obs_key[i]  = '0;
            obs_idx[i]  = '0;
            obs_last[i] = 1'b0;
        end
        start_ready = keyReady;
        keyValid = 1'b1;
        key      = k;
        hit      = CACHE_ON && cache_valid && (cache_key == k);
        exp_lat  = hit ? 0 : 10;
        if (!hit) cache_valid = 1'b0;
        @(posedge clock); #1;
        keyValid = hold_other;
        if (hold_other) key = k2;
        obs_lat = 0;
        while (!roundKeyValid && obs_lat < 40) begin
            if (keyReady) kr_viol++;
            roundKeyReady = 1'($urandom_range(1));
            @(posedge clock); #1;
            obs_lat++;
        end
        if (!roundKeyValid) begin
            timed_out     = 1'b1;
            roundKeyReady = 1'b0;
            return;
        end
        cache_valid = 1'b1;
        cache_key   = k;
        n = 0;
        stalled  = 1'b0;
        prev_key = '0;
        prev_idx = '0;
        while (n < 11 && obs_cycles < 400) begin
            if (!roundKeyValid) break;
            if (keyReady) kr_viol++;
            if (stalled && (roundKey !== prev_key || roundIndex !== prev_idx)) stall_viol++;
            prev_key = roundKey;
            prev_idx = roundIndex;
            roundKeyReady = ($urandom_range(99) < ready_pct);
            if (roundKeyReady) begin
                obs_key[n]  = roundKey;
                obs_idx[n]  = roundIndex;
                obs_last[n] = lastKey;
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
            end
            @(posedge clock); #1;
            obs_cycles++;
        end
        if (n < 11) timed_out = 1'b1;
        roundKeyReady = 1'b0;
        end_kr  = keyReady;
        end_rkv = roundKeyValid;
    endtask

    task automatic test_reset();
        n_total++;
        if ({keyReady, roundKeyValid, roundKey, roundIndex, lastKey} !== {1'b1, 1'b0, 128'h0, 4'h0, 1'b0})
            $display("FAIL reset_state: got kr=%b v=%b rk=%h idx=%0d last=%b, want kr=1 v=0 rk=0 idx=0 last=0",
                     keyReady, roundKeyValid, roundKey, roundIndex, lastKey);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_fips_sequence();
        ref_schedule(FIPS_KEY);
        run_schedule(FIPS_KEY, 100, 1'b0, '0);
        n_total++;
        if ({timed_out, start_ready} !== 2'b01) $display("FAIL fips_handshake: got timeout=%b start_ready=%b, want 0/1", timed_out, start_ready);
        else n_pass++;
        n_total++;
        if (obs_lat !== exp_lat) $display("FAIL fips_latency: got %0d edges, want %0d", obs_lat, exp_lat);
        else n_pass++;
        n_total++;
        if (obs_cycles !== 11) $display("FAIL fips_back_to_back: got %0d cycles, want 11", obs_cycles);
        else n_pass++;
        n_total++;
        if (obs_key[0] !== 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6) $display("FAIL fips_rk10: got %h, want d014f9a8c9ee2589e13f0cc8b6630ca6", obs_key[0]);
        else n_pass++;
        n_total++;
        if (obs_key[9] !== 128'ha0fafe17_88542cb1_23a33939_2a6c7605) $display("FAIL fips_rk1: got %h, want a0fafe1788542cb123a339392a6c7605", obs_key[9]);
        else n_pass++;
        n_total++;
        if ({obs_key[10], obs_last[10]} !== {FIPS_KEY, 1'b1}) $display("FAIL fips_rk0: got %h last=%b, want %h last=1", obs_key[10], obs_last[10], FIPS_KEY);
        else n_pass++;
        for (int i = 0; i < 11; i++) begin
            n_total++;
            if ({obs_key[i], obs_idx[i], obs_last[i]} !== {ref_rk[10-i], 4'(10-i), (i == 10)})
                $display("FAIL fips_round_%0d: got key=%h idx=%0d last=%b, want key=%h idx=%0d last=%b",
                         i, obs_key[i], obs_idx[i], obs_last[i], ref_rk[10-i], 10-i, (i == 10));
            else n_pass++;
        end
        n_total++;
        if ({end_kr, end_rkv, kr_viol} !== {1'b1, 1'b0, 32'd0}) $display("FAIL fips_return_idle: got kr=%b v=%b busy_ready=%0d, want 1/0/0", end_kr, end_rkv, kr_viol);
        else n_pass++;
    endtask

    task automatic test_stall();
        int bad;
        ref_schedule(FIPS_KEY);
        run_schedule(FIPS_KEY, 40, 1'b0, '0);
        bad = 0;
        for (int i = 0; i < 11; i++)
            if ({obs_key[i], obs_idx[i], obs_last[i]} !== {ref_rk[10-i], 4'(10-i), (i == 10)}) bad++;
        n_total++;
        if ({timed_out, bad} !== {1'b0, 32'd0}) $display("FAIL stall_sequence: got timeout=%b bad_rounds=%0d, want 0/0", timed_out, bad);
        else n_pass++;
        n_total++;
        if (stall_viol !== 0) $display("FAIL stall_hold: got %0d output changes while stalled, want 0", stall_viol);
        else n_pass++;
        n_total++;
        if (obs_lat !== exp_lat) $display("FAIL stall_latency: got %0d edges, want %0d", obs_lat, exp_lat);
        else n_pass++;
    endtask

    task automatic test_seq_key();
        run_schedule(SEQ_KEY, 100, 1'b0, '0);
        n_total++;
        if (obs_key[0] !== 128'h13111d7f_e3944a17_f307a78b_4d2b30c5) $display("FAIL seq_rk10: got %h, want 13111d7fe3944a17f307a78b4d2b30c5", obs_key[0]);
        else n_pass++;
        n_total++;
        if ({obs_key[10], obs_idx[10]} !== {SEQ_KEY, 4'd0}) $display("FAIL seq_rk0: got %h idx=%0d, want %h idx=0", obs_key[10], obs_idx[10], SEQ_KEY);
        else n_pass++;
    endtask

    task automatic test_reset_midway();
        logic [127:0] k;
        int guard;
        k = rand128();
        keyValid = 1'b1;
        key      = k;
        @(posedge clock); #1;
        keyValid = 1'b0;
        cache_valid = 1'b0;
        repeat (5) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        n_total++;
        if ({keyReady, roundKeyValid, roundKey, roundIndex, lastKey} !== {1'b1, 1'b0, 128'h0, 4'h0, 1'b0})
            $display("FAIL reset_mid_expand: got kr=%b v=%b rk=%h idx=%0d last=%b, want 1/0/0/0/0",
                     keyReady, roundKeyValid, roundKey, roundIndex, lastKey);
        else n_pass++;
        @(posedge clock); #1;
        reset = 1'b0;
        keyValid = 1'b1;
        key      = k;
        @(posedge clock); #1;
        keyValid = 1'b0;
        guard = 0;
        while (!(roundKeyValid && roundIndex == 4'd4) && guard < 40) begin
            roundKeyReady = roundKeyValid;
            @(posedge clock); #1;
            guard++;
        end
        roundKeyReady = 1'b0;
        n_total++;
        if ({roundKeyValid, roundIndex} !== {1'b1, 4'd4}) $display("FAIL reach_index4: got v=%b idx=%0d, want v=1 idx=4", roundKeyValid, roundIndex);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({keyReady, roundKeyValid, roundKey, roundIndex, lastKey} !== {1'b1, 1'b0, 128'h0, 4'h0, 1'b0})
            $display("FAIL reset_mid_emit: got kr=%b v=%b rk=%h idx=%0d last=%b, want 1/0/0/0/0",
                     keyReady, roundKeyValid, roundKey, roundIndex, lastKey);
        else n_pass++;
        cache_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        k = rand128();
        ref_schedule(k);
        run_schedule(k, 100, 1'b0, '0);
        for (int i = 0; i < 11; i++) begin
            n_total++;
            if ({obs_key[i], obs_idx[i]} !== {ref_rk[10-i], 4'(10-i)})
                $display("FAIL after_reset_round_%0d: got %h idx=%0d, want %h idx=%0d", i, obs_key[i], obs_idx[i], ref_rk[10-i], 10-i);
            else n_pass++;
        end
    endtask

    task automatic test_key_while_busy();
        logic [127:0] k1, k2;
        int bad;
        k1 = rand128();
        k2 = rand128();
        ref_schedule(k1);
        run_schedule(k1, 70, 1'b1, k2);
        bad = 0;
        for (int i = 0; i < 11; i++)
            if ({obs_key[i], obs_idx[i]} !== {ref_rk[10-i], 4'(10-i)}) bad++;
        n_total++;
        if ({timed_out, bad, kr_viol} !== {1'b0, 32'd0, 32'd0}) $display("FAIL busy_ignored: got timeout=%b bad_rounds=%0d busy_ready=%0d, want 0/0/0", timed_out, bad, kr_viol);
        else n_pass++;
        n_total++;
        if ({end_kr, end_rkv} !== 2'b10) $display("FAIL busy_reready: got kr=%b v=%b after final handshake, want 1/0", end_kr, end_rkv);
        else n_pass++;
        ref_schedule(k2);
        run_schedule(k2, 100, 1'b0, '0);
        bad = 0;
        for (int i = 0; i < 11; i++)
            if ({obs_key[i], obs_idx[i]} !== {ref_rk[10-i], 4'(10-i)}) bad++;
        n_total++;
        if ({timed_out, bad, obs_lat} !== {1'b0, 32'd0, exp_lat}) $display("FAIL second_key: got timeout=%b bad_rounds=%0d latency=%0d, want 0/0/%0d", timed_out, bad, obs_lat, exp_lat);
        else n_pass++;
    endtask

    task automatic test_random_keys();
        for (int r = 0; r < 16; r++) begin
            logic [127:0] k;
            int bad;
            k = (r == 8) ? cache_key : rand128();
            ref_schedule(k);
            run_schedule(k, int'($urandom_range(100, 30)), 1'b0, '0);
            bad = 0;
            for (int i = 0; i < 11; i++)
                if ({obs_key[i], obs_idx[i], obs_last[i]} !== {ref_rk[10-i], 4'(10-i), (i == 10)}) bad++;
            n_total++;
            if ({timed_out, bad, stall_viol, obs_lat} !== {1'b0, 32'd0, 32'd0, exp_lat})
                $display("FAIL random_run_%0d: key=%h timeout=%b bad_rounds=%0d stall_changes=%0d latency=%0d, want 0/0/0/%0d",
                         r, k, timed_out, bad, stall_viol, obs_lat, exp_lat);
            else n_pass++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        keyValid      = 1'b0;
        key           = '0;
        roundKeyReady = 1'b0;
        build_sbox();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_fips_sequence();
        test_stall();
        test_seq_key();
        test_reset_midway();
        test_key_while_busy();
        test_random_keys();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
